chunk_adder_seq: RTL and testbench
==================================

# chunk_adder_seq

Parametrised, multi-cycle binary adder/subtractor that is the successor to our fixed 4-bit ripple adder. Operands of WIDTH bits are summed one CHUNK-bit slice per clock, least-significant first, with the carry held in a register between slices. A valid/ready handshake on both sides lets the block sit in any datapath where area matters more than single-cycle latency. Subtraction is a runtime mode: a − b in two's complement.

## Interface
Parameters:
- WIDTH, 16: operand and sum width; must be a multiple of CHUNK (elaboration error otherwise).
- CHUNK, 4: bits added per cycle; 1 ≤ CHUNK ≤ WIDTH.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands presented.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c_in  input  1  carry-in; ignored when sub=1.
- sub  input  1  0: a+b+c_in; 1: a+~b+1.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- s  output  WIDTH  sum/difference.
- c_out  output  1  carry out of MSB; for sub, 1 = no borrow.
- ovf  output  1  signed overflow (only with CHUNK_ADDER_OVF_EN).

## Operation
- NCHUNK = WIDTH/CHUNK. States: IDLE, RUN, DONE.
- IDLE: in_ready=1, out_valid=0. On in_valid & in_ready: latch a, b_eff = sub ? ~b : b, carry = sub ? 1 : c_in; chunk index k=0; go RUN.
- RUN: each cycle, add slice k of a, b_eff and carry through the CHUNK-bit adder; write result into slice k of s; update carry; k++. After slice NCHUNK−1 is written, c_out=carry, go DONE.
- DONE: out_valid=1; s, c_out, ovf held stable. On out_ready go IDLE.
- in_ready=0 in RUN and DONE; in_valid there is ignored (no queuing).
- Input operands are sampled only at the accept edge; later changes on a/b/c_in/sub have no effect.
- Result bits equal (a + b_eff + carry_in) mod 2^WIDTH; c_out is bit WIDTH of the full sum.
- Reset: state IDLE, in_ready=1, out_valid=0, s=0, c_out=0, ovf=0, internal carry and k cleared. Reset mid-RUN or mid-DONE aborts the operation; the result is discarded.
- Reset has priority over any simultaneous handshake.

## Timing
- Accept at edge E → out_valid high from edge E+NCHUNK (latency NCHUNK cycles).
- Minimum issue interval NCHUNK+2 cycles (accept, NCHUNK RUN cycles, DONE handshake, back to IDLE).
- CHUNK=WIDTH: single RUN cycle, latency 1.
- out_ready held high before result: DONE lasts exactly one cycle.
- s is registered. Partial slices are visible during RUN but are not valid until out_valid.

## Configuration
- CHUNK_ADDER_OVF_EN defined: ovf port present. In DONE, ovf = (a[MSB] == b_eff[MSB]) & (s[MSB] != a[MSB]). Cleared by reset.
- Not defined: ovf port and its logic are absent; all other behaviour is identical.

## Structure
- Shared package chunk_adder_pkg: state enum (IDLE/RUN/DONE) and a function for chunk-index width ($clog2 of NCHUNK, minimum 1).
- One sub-module: chunk_add, a combinational CHUNK-bit adder (x, y, cin → sum, cout), instantiated once and reused every cycle.

## Test plan
Tests use WIDTH=16, CHUNK=4.
- a=0x1234, b=0x1111, c_in=0, sub=0 → s=0x2345, c_out=0; out_valid exactly 4 cycles after accept.
- a=0xFFFF, b=0x0001, c_in=0 → s=0x0000, c_out=1 (carry ripples through every slice).
- sub=1, a=0x0005, b=0x0007 → s=0xFFFE, c_out=0; then a=0x0007, b=0x0005 → s=0x0002, c_out=1; c_in toggled with no effect.
- Result pending with out_ready low for 5 cycles; in_valid pulsed meanwhile → s/c_out stable, in_ready=0, extra input not accepted; after out_ready, IDLE next cycle.
- rst asserted for one cycle after 2 RUN cycles → next cycle IDLE, outputs 0; new op a=0x00FF, b=0x0001 → s=0x0100.
- CHUNK_ADDER_OVF_EN: a=0x7FFF, b=0x0001 → ovf=1; sub=1, a=0x8000, b=0x0001 → ovf=1; a=0x0001, b=0x0001 → ovf=0.

Source files
------------

// File: rtl/chunk_adder_pkg.sv
// Shared types and helpers for the chunked sequential adder.
package chunk_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the chunk index register; never narrower than one bit.
  function automatic int idx_width(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/chunk_add.sv
// Combinational CHUNK-bit adder slice with carry in/out.
module chunk_add #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK:0] total;

  assign total = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
  assign sum   = total[CHUNK-1:0];
  assign cout  = total[CHUNK];

endmodule

// File: rtl/chunk_adder_seq.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock, LSB slice first.
// Optional signed-overflow output enabled by defining CHUNK_ADDER_OVF_EN.
module chunk_adder_seq
  import chunk_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out
`ifdef CHUNK_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int            NCHUNK = WIDTH / CHUNK;
  localparam int            KW     = idx_width(NCHUNK);
  localparam logic [KW-1:0] LAST_K = KW'(NCHUNK - 1);

  generate
    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_param
      $error("chunk_adder_seq: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;      // already inverted for subtraction
  logic [WIDTH-1:0] s_reg;
  logic             carry_reg;
  logic [KW-1:0]    k_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic             c_out_reg;

  logic [CHUNK-1:0] a_chunks [NCHUNK];
  logic [CHUNK-1:0] b_chunks [NCHUNK];
  logic [CHUNK-1:0] slice_a;
  logic [CHUNK-1:0] slice_b;
  logic [CHUNK-1:0] sum_chunk;
  logic             carry_next;

  generate
    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_slice
      assign a_chunks[gi] = a_reg[gi*CHUNK +: CHUNK];
      assign b_chunks[gi] = b_reg[gi*CHUNK +: CHUNK];
    end
  endgenerate

  assign slice_a = a_chunks[k_reg];
  assign slice_b = b_chunks[k_reg];

  chunk_add #(
    .CHUNK(CHUNK)
  ) u_add (
    .x   (slice_a),
    .y   (slice_b),
    .cin (carry_reg),
    .sum (sum_chunk),
    .cout(carry_next)
  );

`ifdef CHUNK_ADDER_OVF_EN
  logic ovf_reg;

  // On the last slice sum_chunk holds the result MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_reg <= 1'b0;
    end else if (state_reg == RUN && k_reg == LAST_K) begin
      ovf_reg <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                 (sum_chunk[CHUNK-1] != a_reg[WIDTH-1]);
    end
  end

  assign ovf = ovf_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      a_reg         <= '0;
      b_reg         <= '0;
      s_reg         <= '0;
      carry_reg     <= 1'b0;
      k_reg         <= '0;
      c_out_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg        <= a;
            b_reg        <= sub ? ~b : b;
            carry_reg    <= sub ? 1'b1 : c_in;
            k_reg        <= '0;
            in_ready_reg <= 1'b0;
            state_reg    <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < NCHUNK; i++) begin
            if (k_reg == KW'(i)) begin
              s_reg[i*CHUNK +: CHUNK] <= sum_chunk;
            end
          end
          carry_reg <= carry_next;
          k_reg     <= k_reg + KW'(1);
          if (k_reg == LAST_K) begin
            c_out_reg     <= carry_next;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign s         = s_reg;
  assign c_out     = c_out_reg;

endmodule

// File: tb/tb_chunk_adder_seq.sv
// Self-checking bench for chunk_adder_seq (WIDTH=16, CHUNK=4) against an arithmetic model.
module tb_chunk_adder_seq;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        c_in;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] s;
  logic        c_out;
`ifdef CHUNK_ADDER_OVF_EN
  logic        ovf;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  chunk_adder_seq #(.WIDTH(16), .CHUNK(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .s        (s),
    .c_out    (c_out)
`ifdef CHUNK_ADDER_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: 17-bit result {c_out, s}; subtraction is a - b + 2^16.
  function automatic logic [16:0] ref_sum(input logic [15:0] x, input logic [15:0] y,
                                          input logic ci, input logic sb);
    logic [16:0] r;
    if (sb) r = 17'(x) + 17'd65536 - 17'(y);
    else    r = 17'(x) + 17'(y) + 17'(ci);
    return r;
  endfunction

  // Reference: true signed result does not fit in 16 bits.
  function automatic logic ref_ovf(input logic [15:0] x, input logic [15:0] y,
                                   input logic ci, input logic sb);
    int sx;
    int sy;
    int r;
    sx = int'($signed(x));
    sy = int'($signed(y));
    r  = sb ? (sx - sy) : (sx + sy + int'(ci));
    return (r > 32767) || (r < -32768);
  endfunction

  // Presents one operation, scrambles inputs after the accept edge and waits for
  // out_valid; returns at the negedge where out_valid was seen, lat = cycles after accept.
  task automatic issue(input logic [15:0] av, input logic [15:0] bv,
                       input logic ci, input logic sb, output int lat);
    @(negedge clk);
    a = av; b = bv; c_in = ci; sub = sb; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom);
    c_in = 1'($urandom); sub = 1'($urandom);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || s !== 16'h0 || c_out !== 1'b0) begin
      errors++;
      $display("FAIL reset: in_ready=%b out_valid=%b s=%h c_out=%b, expected 1 0 0000 0",
               in_ready, out_valid, s, c_out);
    end
    $display("reset: in_ready=%b out_valid=%b s=%h", in_ready, out_valid, s);
  endtask

  task automatic test_directed();
    logic [15:0] va [6] = '{16'h1234, 16'hFFFF, 16'h0005, 16'h0007, 16'h0007, 16'h1234};
    logic [15:0] vb [6] = '{16'h1111, 16'h0001, 16'h0007, 16'h0005, 16'h0005, 16'h1111};
    logic        vc [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic        vs [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [15:0] es [6] = '{16'h2345, 16'h0000, 16'hFFFE, 16'h0002, 16'h0002, 16'h2346};
    logic        ec [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    int lat;
    for (int i = 0; i < 6; i++) begin
      issue(va[i], vb[i], vc[i], vs[i], lat);
      checks++;
      if (lat !== N) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got %0d cycles, expected %0d", i, lat, N);
      end
      checks++;
      if (s !== es[i] || c_out !== ec[i] || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL directed_result[%0d]: s=%h c_out=%b in_ready=%b, expected s=%h c_out=%b in_ready=0",
                 i, s, c_out, in_ready, es[i], ec[i]);
      end
      $display("directed[%0d]: a=%h b=%h c_in=%b sub=%b -> s=%h c_out=%b lat=%0d",
               i, va[i], vb[i], vc[i], vs[i], s, c_out, lat);
      retire();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL directed_idle[%0d]: out_valid=%b in_ready=%b, expected 0 1",
                 i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    logic        rs;
    logic [16:0] exp;
    int lat;
    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rc = 1'($urandom);  rs = 1'($urandom);
      if (i < 4) ra = 16'hFFFF;
      exp = ref_sum(ra, rb, rc, rs);
      issue(ra, rb, rc, rs, lat);
      checks++;
      if (lat !== N || s !== exp[15:0] || c_out !== exp[16]) begin
        errors++;
        $display("FAIL random[%0d]: s=%h c_out=%b lat=%0d, expected s=%h c_out=%b lat=%0d",
                 i, s, c_out, lat, exp[15:0], exp[16], N);
      end
`ifdef CHUNK_ADDER_OVF_EN
      checks++;
      if (ovf !== ref_ovf(ra, rb, rc, rs)) begin
        errors++;
        $display("FAIL random_ovf[%0d]: ovf=%b expected %b", i, ovf, ref_ovf(ra, rb, rc, rs));
      end
`endif
      $display("random[%0d]: a=%h b=%h c_in=%b sub=%b -> s=%h c_out=%b", i, ra, rb, rc, rs, s, c_out);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      retire();
    end
  endtask

  task automatic test_backpressure();
    logic [16:0] exp;
    int lat;
    int stray;
    exp = ref_sum(16'hABCD, 16'h1234, 1'b1, 1'b0);
    issue(16'hABCD, 16'h1234, 1'b1, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || s !== exp[15:0] || c_out !== exp[16]) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: out_valid=%b in_ready=%b s=%h c_out=%b, expected 1 0 %h %b",
                 i, out_valid, in_ready, s, c_out, exp[15:0], exp[16]);
      end
    end
    in_valid = 1'b0;
    retire();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release: out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
    end
    stray = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL backpressure_no_queue: %0d cycles busy, expected 0", stray);
    end
    $display("backpressure: s=%h c_out=%b held 5 cycles", exp[15:0], exp[16]);
  endtask

  task automatic test_reset_abort();
    int lat;
    int stray;
    @(negedge clk);
    a = 16'h4321; b = 16'h1111; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || s !== 16'h0 || c_out !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset: in_ready=%b out_valid=%b s=%h c_out=%b, expected 1 0 0000 0",
               in_ready, out_valid, s, c_out);
    end
    // Reset wins over a simultaneous accept.
    rst = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    stray = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL reset_priority: %0d cycles busy, expected 0", stray);
    end
    issue(16'h00FF, 16'h0001, 1'b0, 1'b0, lat);
    checks++;
    if (lat !== N || s !== 16'h0100 || c_out !== 1'b0) begin
      errors++;
      $display("FAIL abort_recover: s=%h c_out=%b lat=%0d, expected 0100 0 %0d", s, c_out, lat, N);
    end
    $display("reset_abort: recovered s=%h c_out=%b", s, c_out);
    retire();
  endtask

  task automatic test_back_to_back();
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    logic        rs;
    logic [16:0] exp;
    int prev_acc;
    int acc;
    int waitc;
    out_ready = 1'b1;
    prev_acc = -1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      exp = ref_sum(ra, rb, rc, rs);
      a = ra; b = rb; c_in = rc; sub = rs; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      acc = cyc;
      in_valid = 1'b0;
      waitc = 0;
      while (out_valid !== 1'b1 && waitc < 40) begin
        @(negedge clk);
        waitc++;
      end
      checks++;
      if (waitc !== N || s !== exp[15:0] || c_out !== exp[16]) begin
        errors++;
        $display("FAIL b2b_result[%0d]: s=%h c_out=%b lat=%0d, expected %h %b %0d",
                 i, s, c_out, waitc, exp[15:0], exp[16], N);
      end
      if (prev_acc >= 0) begin
        checks++;
        if (acc - prev_acc != N + 2) begin
          errors++;
          $display("FAIL b2b_interval[%0d]: %0d cycles, expected %0d", i, acc - prev_acc, N + 2);
        end
      end
      prev_acc = acc;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_done_one_cycle[%0d]: out_valid=%b in_ready=%b, expected 0 1",
                 i, out_valid, in_ready);
      end
      $display("b2b[%0d]: a=%h b=%h sub=%b -> s=%h c_out=%b", i, ra, rb, rs, exp[15:0], exp[16]);
    end
    out_ready = 1'b0;
  endtask

`ifdef CHUNK_ADDER_OVF_EN
  task automatic test_ovf();
    logic [15:0] va [4] = '{16'h7FFF, 16'h8000, 16'h0001, 16'h8000};
    logic [15:0] vb [4] = '{16'h0001, 16'h0001, 16'h0001, 16'h8000};
    logic        vs [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic        eo [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    int lat;
    for (int i = 0; i < 4; i++) begin
      issue(va[i], vb[i], 1'b0, vs[i], lat);
      checks++;
      if (ovf !== eo[i]) begin
        errors++;
        $display("FAIL ovf[%0d]: ovf=%b expected %b", i, ovf, eo[i]);
      end
      $display("ovf[%0d]: a=%h b=%h sub=%b -> ovf=%b", i, va[i], vb[i], vs[i], ovf);
      retire();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
`ifdef CHUNK_ADDER_OVF_EN
    test_ovf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
